// File: rtl/oflow_core_read_sequencer.sv
// oflow_core_read_sequencer: walks a frame set by set, issuing start_read and collecting PE new-line requests
module oflow_core_read_sequencer #(
  parameter int PE_NUM          = 24,
  parameter int SET_LEN         = 4,
  parameter int REMAIN_BBOX_LEN = 5
) (
  input  logic                       clk,
  input  logic                       reset_N,
  input  logic                       start_frame,
  input  logic                       abort,
  input  logic [SET_LEN-1:0]         num_of_sets,
  input  logic [REMAIN_BBOX_LEN-1:0] counter_of_remain_bboxes,
  input  logic                       done_read,
  input  logic                       done_registration,
  input  logic [PE_NUM-1:0]          control_for_read_new_line,
  output logic                       start_read,
  output logic                       read_new_line,
  output logic [PE_NUM-1:0]          active_pe_mask,
  output logic [SET_LEN-1:0]         counter_set,
  output logic                       busy,
  output logic                       done_frame
);
  typedef enum logic [2:0] {IDLE, START, READ, WAIT_REG, DONE} state_t;
  localparam logic [REMAIN_BBOX_LEN-1:0] PE_CNT = REMAIN_BBOX_LEN'(PE_NUM);
  state_t                     state;
  logic [SET_LEN-1:0]         sets_q, sets_src, next_set;
  logic [REMAIN_BBOX_LEN-1:0] rem_q, rem_in, rem_src;
  logic [PE_NUM-1:0]          last_mask, next_mask;
  logic                       reg_seen, all_req, all_req_d, reg_done, cur_last, next_last;
  // clamp the remaining-bbox count and work out the mask for the set being entered
  always_comb begin
    rem_in    = (counter_of_remain_bboxes == '0 || counter_of_remain_bboxes > PE_CNT) ? PE_CNT : counter_of_remain_bboxes;
    rem_src   = (state == IDLE) ? rem_in : rem_q;
    sets_src  = (state == IDLE) ? num_of_sets : sets_q;
    next_set  = (state == IDLE) ? '0 : counter_set + SET_LEN'(1);
    last_mask = ~({PE_NUM{1'b1}} << rem_src);
    next_last = next_set == sets_src - SET_LEN'(1);
    next_mask = next_last ? last_mask : {PE_NUM{1'b1}};
    cur_last  = counter_set == sets_q - SET_LEN'(1);
    reg_done  = reg_seen | done_registration;
    all_req   = (state == READ) && ((control_for_read_new_line & active_pe_mask) == active_pe_mask);
  end
  // sequencer state, sticky registration flag and registered pulse outputs
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state          <= IDLE;
      sets_q         <= '0;
      rem_q          <= '0;
      counter_set    <= '0;
      active_pe_mask <= '0;
      reg_seen       <= 1'b0;
      all_req_d      <= 1'b0;
      start_read     <= 1'b0;
      read_new_line  <= 1'b0;
      done_frame     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      start_read    <= 1'b0;
      done_frame    <= 1'b0;
      read_new_line <= 1'b0;
      all_req_d     <= all_req;
      if (abort) begin
        state       <= IDLE;
        counter_set <= '0;
        reg_seen    <= 1'b0;
        all_req_d   <= 1'b0;
        busy        <= 1'b0;
      end else begin
        read_new_line <= all_req & ~all_req_d;
        case (state)
          IDLE: begin
            reg_seen <= 1'b0;
            if (start_frame) begin
              sets_q      <= num_of_sets;
              rem_q       <= rem_in;
              counter_set <= '0;
              busy        <= 1'b1;
              if (num_of_sets == '0) begin
                state      <= DONE;
                done_frame <= 1'b1;
              end else begin
                state          <= START;
                start_read     <= 1'b1;
                active_pe_mask <= next_mask;
              end
            end
          end
          START: begin
            state <= READ;
            if (done_registration) reg_seen <= 1'b1;
          end
          READ: begin
            if (done_registration) reg_seen <= 1'b1;
            if (done_read) state <= WAIT_REG;
          end
          WAIT_REG: begin
            if (reg_done) begin
              reg_seen <= 1'b0;
              if (cur_last) begin
                state      <= DONE;
                done_frame <= 1'b1;
              end else begin
                state          <= START;
                counter_set    <= next_set;
                start_read     <= 1'b1;
                active_pe_mask <= next_mask;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_oflow_core_read_sequencer.sv
// tb_oflow_core_read_sequencer: directed table-driven bench for the core read sequencer
module tb_oflow_core_read_sequencer;
  logic        clk = 1'b0;
  logic        reset_N, start_frame, abort, done_read, done_registration;
  logic [3:0]  num_of_sets;
  logic [4:0]  counter_of_remain_bboxes;
  logic [23:0] control_for_read_new_line;
  logic        start_read, read_new_line, busy, done_frame;
  logic [23:0] active_pe_mask;
  logic [3:0]  counter_set;
  int          checks = 0;
  int          errors = 0;

  typedef struct {logic [3:0] ns; logic [4:0] rm; int starts; logic [23:0] mask;} frame_t;
  typedef struct {logic [23:0] ctrl; int pulses;} line_t;
  frame_t fv[7];
  line_t  lv[5];

  always #5 clk = ~clk;

  oflow_core_read_sequencer dut (
    .clk(clk), .reset_N(reset_N), .start_frame(start_frame), .abort(abort),
    .num_of_sets(num_of_sets), .counter_of_remain_bboxes(counter_of_remain_bboxes),
    .done_read(done_read), .done_registration(done_registration),
    .control_for_read_new_line(control_for_read_new_line),
    .start_read(start_read), .read_new_line(read_new_line), .active_pe_mask(active_pe_mask),
    .counter_set(counter_set), .busy(busy), .done_frame(done_frame)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [3:0] ns, input logic [4:0] rm);
    num_of_sets = ns;
    counter_of_remain_bboxes = rm;
    start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
  endtask

  task automatic advance();
    done_read = 1'b1;
    tick();
    done_read = 1'b0;
    done_registration = 1'b1;
    tick();
    done_registration = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic run_frame(input logic [3:0] ns, input logic [4:0] rm, output int starts,
                           output int dones, output logic [23:0] last_mask, output int seq_err, output int fin);
    int ph;
    start(ns, rm);
    starts = 0; dones = 0; seq_err = 0; fin = 0; ph = -1; last_mask = '0;
    for (int k = 0; k < 400 && fin == 0; k++) begin
      if (start_read) begin
        if (counter_set != 4'(starts)) seq_err++;
        if (counter_set != ns - 4'd1 && active_pe_mask != 24'hFFFFFF) seq_err++;
        last_mask = active_pe_mask;
        starts++;
        ph = 0;
      end
      if (done_frame) dones++;
      if (dones > 0 && !busy) fin = 1;
      done_read = (ph == 4);
      done_registration = (ph == 6);
      if (ph >= 0) ph++;
      if (fin == 0) tick();
    end
    done_read = 1'b0;
    done_registration = 1'b0;
  endtask

  initial begin
    int starts, dones, seq_err, fin, cnt;
    logic [23:0] lm;
    fv[0] = '{4'd3,  5'd5,  3,  24'h00001F};
    fv[1] = '{4'd1,  5'd0,  1,  24'hFFFFFF};
    fv[2] = '{4'd2,  5'd24, 2,  24'hFFFFFF};
    fv[3] = '{4'd2,  5'd30, 2,  24'hFFFFFF};
    fv[4] = '{4'd15, 5'd1,  15, 24'h000001};
    fv[5] = '{4'd0,  5'd5,  0,  24'h000000};
    fv[6] = '{4'd4,  5'd23, 4,  24'h7FFFFF};
    lv[0] = '{24'h00001F, 1};
    lv[1] = '{24'h00000F, 0};
    lv[2] = '{24'hFFFFE0, 0};
    lv[3] = '{24'hFFFFFF, 1};
    lv[4] = '{24'h10001F, 1};

    reset_N = 1'b0; start_frame = 1'b0; abort = 1'b0; done_read = 1'b0;
    done_registration = 1'b0; num_of_sets = '0; counter_of_remain_bboxes = '0;
    control_for_read_new_line = '0;
    tick(); tick();
    chk("rst_start_read", {31'd0, start_read}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done_frame", {31'd0, done_frame}, 0);
    chk("rst_read_new_line", {31'd0, read_new_line}, 0);
    chk("rst_counter_set", {28'd0, counter_set}, 0);
    chk("rst_mask", {8'd0, active_pe_mask}, 0);
    reset_N = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_frame(fv[i].ns, fv[i].rm, starts, dones, lm, seq_err, fin);
      chk($sformatf("frame%0d_finished", i), fin, 1);
      chk($sformatf("frame%0d_starts", i), starts, fv[i].starts);
      chk($sformatf("frame%0d_done_frames", i), dones, 1);
      chk($sformatf("frame%0d_seq", i), seq_err, 0);
      if (fv[i].starts > 0) chk($sformatf("frame%0d_last_mask", i), {8'd0, lm}, {8'd0, fv[i].mask});
      tick();
    end

    start(4'd3, 5'd5);
    tick();
    advance();
    tick();
    advance();
    chk("set2_start_read", {31'd0, start_read}, 1);
    chk("set2_counter", {28'd0, counter_set}, 2);
    chk("set2_mask", {8'd0, active_pe_mask}, 24'h00001F);
    tick();
    for (int i = 0; i < 5; i++) begin
      control_for_read_new_line = '0;
      tick();
      control_for_read_new_line = lv[i].ctrl;
      tick();
      chk($sformatf("line%0d_latency", i), {31'd0, read_new_line}, 32'(lv[i].pulses));
      cnt = read_new_line;
      repeat (3) begin tick(); cnt += read_new_line; end
      chk($sformatf("line%0d_pulses", i), cnt, lv[i].pulses);
    end
    control_for_read_new_line = '0;
    do_abort();

    start(4'd2, 5'd0);
    chk("held_start_read", {31'd0, start_read}, 1);
    tick();
    control_for_read_new_line = 24'hFFFFFF;
    cnt = 0;
    repeat (10) begin tick(); cnt += read_new_line; end
    chk("held_one_pulse", cnt, 1);
    control_for_read_new_line = '0;
    tick();
    cnt += read_new_line;
    control_for_read_new_line = 24'hFFFFFF;
    repeat (3) begin tick(); cnt += read_new_line; end
    chk("held_second_pulse", cnt, 2);
    control_for_read_new_line = '0;

    done_registration = 1'b1;
    tick();
    done_registration = 1'b0;
    tick(); tick();
    done_read = 1'b1;
    tick();
    done_read = 1'b0;
    chk("early_reg_t1", {31'd0, start_read}, 0);
    tick();
    chk("early_reg_t2", {31'd0, start_read}, 1);
    chk("early_reg_counter", {28'd0, counter_set}, 1);
    chk("rem0_mask", {8'd0, active_pe_mask}, 24'hFFFFFF);
    tick();
    done_read = 1'b1;
    tick();
    done_read = 1'b0;
    done_registration = 1'b1;
    tick();
    done_registration = 1'b0;
    chk("end_done_frame", {31'd0, done_frame}, 1);
    chk("end_busy_t1", {31'd0, busy}, 1);
    tick();
    chk("end_busy_t2", {31'd0, busy}, 0);
    chk("end_done_frame_t2", {31'd0, done_frame}, 0);

    start(4'd3, 5'd5);
    tick();
    advance();
    tick();
    chk("abort_pre_counter", {28'd0, counter_set}, 1);
    do_abort();
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_counter", {28'd0, counter_set}, 0);
    cnt = 0;
    repeat (4) begin cnt += done_frame + start_read; tick(); end
    chk("abort_quiet", cnt, 0);
    start(4'd3, 5'd5);
    chk("restart_start_read", {31'd0, start_read}, 1);
    chk("restart_counter", {28'd0, counter_set}, 0);
    do_abort();

    num_of_sets = 4'd3;
    start_frame = 1'b1;
    abort = 1'b1;
    tick();
    start_frame = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", {31'd0, busy}, 0);
    tick();
    chk("abort_start_no_read", {31'd0, start_read}, 0);

    start(4'd3, 5'd5);
    tick();
    advance();
    tick();
    done_read = 1'b1;
    tick();
    done_read = 1'b0;
    chk("wait_reg_busy", {31'd0, busy}, 1);
    #1 reset_N = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 0);
    chk("async_rst_counter", {28'd0, counter_set}, 0);
    chk("async_rst_mask", {8'd0, active_pe_mask}, 0);
    chk("async_rst_pulses", {29'd0, start_read, done_frame, read_new_line}, 0);
    tick();
    reset_N = 1'b1;
    tick();
    chk("post_rst_idle", {31'd0, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
